// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// UART_TX_PARITY_EN adds the even-parity state and lengthens the frame to 11 bits.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS  = 8;
   localparam logic        UART_IDLE_LEVEL = 1'b1;

`ifdef UART_TX_PARITY_EN
   localparam int unsigned UART_FRAME_BITS = 11;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_tx_state_t;
`else
   localparam int unsigned UART_FRAME_BITS = 10;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } uart_tx_state_t;
`endif

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Valid/ready byte handshake between the sensor data path and the UART transmitter.
interface uart_tx_ctrl_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/uart_bit_timer.sv
// Baud counter: counts 0..CLK_PER_BIT-1 while run is high, ticks on the last count.
module uart_bit_timer #(
   parameter int unsigned CLK_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic bit_tick
);

   localparam int unsigned   CntW    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(CLK_PER_BIT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign bit_tick = run && (cnt_q == LastCnt);

   always_comb begin
      cnt_d = cnt_q + CntW'(1);
      if (!run || bit_tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a byte over valid/ready and serialises it 8N1
// (8E1 when UART_TX_PARITY_EN is defined) with a registered tx line.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned CLK_PER_BIT = 4
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_ctrl_if.slave  tx_if,
   output logic           tx,
   output logic           busy,
   output logic           tx_done
);

   uart_tx_state_t state_q, state_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [2:0]                bit_idx_q, bit_idx_d;
   logic                      tx_q, tx_d;
   logic                      tx_done_q, tx_done_d;
   logic                      bit_tick;
   logic                      accept;
`ifdef UART_TX_PARITY_EN
   logic                      parity_q, parity_d;
`endif

   uart_bit_timer #(
      .CLK_PER_BIT(CLK_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .run      (state_q != StIdle),
      .bit_tick (bit_tick)
   );

   assign tx_if.tx_ready = (state_q == StIdle);
   assign busy           = ~tx_if.tx_ready;
   assign tx             = tx_q;
   assign tx_done        = tx_done_q;
   assign accept         = tx_if.tx_valid && tx_if.tx_ready;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               shift_d   = tx_if.tx_data;
               bit_idx_d = '0;
               state_d   = StStart;
`ifdef UART_TX_PARITY_EN
               parity_d  = ^tx_if.tx_data;
`endif
            end
         end
         StStart: begin
            if (bit_tick) state_d = StData;
         end
         StData: begin
            if (bit_tick) begin
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (bit_tick) state_d = StStop;
         end
`endif
         StStop: begin
            if (bit_tick) begin
               state_d   = StIdle;
               tx_done_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // tx is registered from the next state so each bit appears the cycle its state begins
      unique case (state_d)
         StStart:  tx_d = ~UART_IDLE_LEVEL;
         StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = parity_d;
`endif
         default:  tx_d = UART_IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= UART_IDLE_LEVEL;
         tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
         tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed scenarios plus random bytes against
// a frame-level model of the expected tx waveform.
module tb_uart_tx_ctrl;
   import uart_pkg::*;

   localparam int unsigned Cpb = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx, busy, tx_done;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int last_accept = 0;

   uart_tx_ctrl_if u_if ();

   uart_tx_ctrl #(
      .CLK_PER_BIT(Cpb)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_if   (u_if.slave),
      .tx      (tx),
      .busy    (busy),
      .tx_done (tx_done)
   );

   always #5 clk = ~clk;

   task automatic wait_clk();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_tx"}, 32'(tx), 32'd1);
      check({tag, "_ready"}, 32'(u_if.tx_ready), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(tx_done), 32'd0);
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         check_idle(tag);
         wait_clk();
      end
   endtask

   // Sends one byte and checks every cycle of the frame plus the done cycle.
   // hold keeps tx_valid high with nxt so the done cycle's closing edge accepts again.
   task automatic send(input logic [7:0] b, input bit hold, input logic [7:0] nxt,
                       input bit scramble, input bit chk_gap);
      logic exp_bits[$];
      int   total;
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
      if (UART_FRAME_BITS == UART_DATA_BITS + 3) exp_bits.push_back(^b);
      exp_bits.push_back(1'b1);
      total = exp_bits.size() * Cpb;

      check("ready_before_accept", 32'(u_if.tx_ready), 32'd1);
      u_if.tx_valid = 1'b1;
      u_if.tx_data  = b;
      wait_clk();
      if (chk_gap) check("b2b_accept_period", 32'(cyc - last_accept), 32'(UART_FRAME_BITS * Cpb + 1));
      last_accept = cyc;

      for (int i = 0; i < total; i++) begin
         check("frame_tx", 32'(tx), 32'(exp_bits[i / Cpb]));
         check("frame_ready", 32'(u_if.tx_ready), 32'd0);
         check("frame_busy", 32'(busy), 32'd1);
         check("frame_done", 32'(tx_done), 32'd0);
         if (hold) begin
            u_if.tx_valid = 1'b1;
            u_if.tx_data  = nxt;
         end else begin
            u_if.tx_valid = (i == total - 1) ? 1'b0 : 1'($urandom);
            u_if.tx_data  = scramble ? 8'hFF : 8'($urandom);
         end
         wait_clk();
      end

      check("done_pulse", 32'(tx_done), 32'd1);
      check("done_ready", 32'(u_if.tx_ready), 32'd1);
      check("done_tx", 32'(tx), 32'd1);
      check("done_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [7:0] rb;
      int         gap;

      u_if.tx_valid = 1'b0;
      u_if.tx_data  = 8'h00;

      // Reset for two cycles, then quiet line
      rst = 1'b1;
      wait_clk();
      wait_clk();
      check_idle("reset");
      rst = 1'b0;
      idle_cycles(20, "post_reset");

      // Single frames
      send(8'hA5, 1'b0, 8'h00, 1'b0, 1'b0);
      wait_clk();
      idle_cycles(3, "after_a5");
      send(8'h07, 1'b0, 8'h00, 1'b0, 1'b0);
      wait_clk();
      idle_cycles(2, "after_07");

      // Back-to-back with tx_valid held high
      send(8'h55, 1'b1, 8'h0F, 1'b0, 1'b0);
      send(8'h0F, 1'b0, 8'h00, 1'b0, 1'b1);
      wait_clk();
      idle_cycles(2, "after_b2b");

      // tx_data changes right after accept
      send(8'h3C, 1'b0, 8'h00, 1'b1, 1'b0);
      wait_clk();
      idle_cycles(2, "after_3c");

      // Reset during data bit 3 of 0x81
      u_if.tx_valid = 1'b1;
      u_if.tx_data  = 8'h81;
      wait_clk();
      u_if.tx_valid = 1'b0;
      for (int i = 0; i < 17; i++) wait_clk();
      check("midframe_bit3_tx", 32'(tx), 32'd0);
      check("midframe_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      wait_clk();
      rst = 1'b0;
      idle_cycles(45, "after_midframe_rst");
      send(8'h81, 1'b0, 8'h00, 1'b0, 1'b0);
      wait_clk();
      idle_cycles(1, "after_81");

      // Random bytes with random idle gaps
      for (int k = 0; k < 8; k++) begin
         rb  = 8'($urandom);
         gap = int'($urandom_range(0, 3));
         send(rb, 1'b0, 8'h00, 1'b0, 1'b0);
         wait_clk();
         idle_cycles(gap + 1, "rand_gap");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
